// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial
// readout path (binary-to-BCD conversion).
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FMT   = 2'd2,
        HOLD  = 2'd3
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    // Width needed to count 0..digits inclusive.
    function automatic int ndig_w(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction:
// digits of 5 or more get +3 before the shift.
module bcd_add3
    import fact_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Combinational add-3 correction.
    always_comb begin
        q = d;
        if (d >= BCD_ADJ_THRESH)
            q = d + BCD_ADJ;
    end

endmodule

// File: rtl/fact_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter
// with valid/ready handshakes on both sides.
module fact_bin2bcd
    import fact_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BIN_W-1:0]            bin_i,
    input  logic                        bin_valid_i,
    output logic                        bin_ready_o,
    output logic [4*DIGITS-1:0]         bcd_o,
    output logic [ndig_w(DIGITS)-1:0]   ndigits_o,
    output logic                        bcd_valid_o,
    input  logic                        bcd_ready_i,
    output logic                        busy_o
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int NDW   = ndig_w(DIGITS);
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    // log10(2) ~= 0.30103, rounded up to whole digits.
    localparam int MIN_DIGITS = (BIN_W * 30103 + 99999) / 100000;

    if (DIGITS < MIN_DIGITS) begin : g_chk
        $error("fact_bin2bcd: DIGITS too small for BIN_W");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    bcd_state_t         state;
    logic [BIN_W-1:0]   shreg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic [NDW-1:0]     nd;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // Significant-digit count of the accumulator; zero reports one digit.
    always_comb begin
        nd = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] != 4'd0)
                nd = NDW'(i + 1);
        end
    end

    assign bin_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    // Conversion FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            bcd_o       <= '0;
            ndigits_o   <= NDW'(1);
            bcd_valid_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bin_valid_i) begin
                        shreg <= bin_i;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= ACC_W'({acc_adj, shreg[BIN_W-1]});
                    shreg <= shreg << 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT)
                        state <= FMT;
                end
                FMT: begin
                    bcd_o       <= acc;
                    ndigits_o   <= nd;
                    bcd_valid_o <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bcd_ready_i) begin
                        bcd_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_bin2bcd.sv
// Directed bench for fact_bin2bcd: vector table
// plus backpressure and mid-conversion reset sequences.
module tb_fact_bin2bcd;

    logic        clk;
    logic        rst_n;
    logic [31:0] bin_i;
    logic        bin_valid_i;
    logic        bin_ready_o;
    logic [39:0] bcd_o;
    logic [3:0]  ndigits_o;
    logic        bcd_valid_o;
    logic        bcd_ready_i;
    logic        busy_o;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] bin;
        logic [39:0] bcd;
        logic [3:0]  nd;
        bit          early;
    } vec_t;

    vec_t vecs[8];

    fact_bin2bcd #(.BIN_W(32), .DIGITS(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bin_i       (bin_i),
        .bin_valid_i (bin_valid_i),
        .bin_ready_o (bin_ready_o),
        .bcd_o       (bcd_o),
        .ndigits_o   (ndigits_o),
        .bcd_valid_o (bcd_valid_o),
        .bcd_ready_i (bcd_ready_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges after the accept edge until bcd_valid_o rises.
    task automatic wait_valid(input string nm, output int k);
        k = 0;
        while (!bcd_valid_o && k < 100) begin
            tick();
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'd33);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int k;
        chk({nm, "_ready_before"}, 64'(bin_ready_o), 64'd1);
        bin_i       = v.bin;
        bin_valid_i = 1'b1;
        bcd_ready_i = v.early;
        tick();
        bin_valid_i = 1'b0;
        bin_i       = ~v.bin;
        chk({nm, "_busy"}, 64'(busy_o), 64'd1);
        wait_valid(nm, k);
        chk({nm, "_bcd"}, 64'(bcd_o), 64'(v.bcd));
        chk({nm, "_nd"}, 64'(ndigits_o), 64'(v.nd));
        chk({nm, "_rdy_hold"}, 64'(bin_ready_o), 64'd0);
        bcd_ready_i = 1'b1;
        tick();
        bcd_ready_i = 1'b0;
        chk({nm, "_valid_drop"}, 64'(bcd_valid_o), 64'd0);
        chk({nm, "_rdy_after"}, 64'(bin_ready_o), 64'd1);
        chk({nm, "_bcd_kept"}, 64'(bcd_o), 64'(v.bcd));
    endtask

    initial begin
        int k;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bin_i       = '0;
        bin_valid_i = 1'b0;
        bcd_ready_i = 1'b0;

        vecs[0] = '{32'd120,        40'h0000000120, 4'd3,  1'b1};
        vecs[1] = '{32'd479001600,  40'h0479001600, 4'd9,  1'b0};
        vecs[2] = '{32'd0,          40'h0000000000, 4'd1,  1'b0};
        vecs[3] = '{32'd1,          40'h0000000001, 4'd1,  1'b1};
        vecs[4] = '{32'hFFFFFFFF,   40'h4294967295, 4'd10, 1'b0};
        vecs[5] = '{32'd9999999,    40'h0009999999, 4'd7,  1'b0};
        vecs[6] = '{32'd1000000000, 40'h1000000000, 4'd10, 1'b0};
        vecs[7] = '{32'd24,         40'h0000000024, 4'd2,  1'b0};

        #12;
        chk("rst_ready", 64'(bin_ready_o), 64'd1);
        chk("rst_busy",  64'(busy_o),      64'd0);
        chk("rst_valid", 64'(bcd_valid_o), 64'd0);
        chk("rst_bcd",   64'(bcd_o),       64'd0);
        chk("rst_nd",    64'(ndigits_o),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: hold result while a new value waits.
        bin_i       = 32'd5040;
        bin_valid_i = 1'b1;
        tick();
        bin_valid_i = 1'b0;
        wait_valid("bp_first", k);
        chk("bp_first_bcd", 64'(bcd_o), 64'h5040);
        bin_i       = 32'd720;
        bin_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_stall_bcd",   64'(bcd_o),       64'h5040);
            chk("bp_stall_rdy",   64'(bin_ready_o), 64'd0);
            chk("bp_stall_valid", 64'(bcd_valid_o), 64'd1);
        end
        bcd_ready_i = 1'b1;
        tick();
        bcd_ready_i = 1'b0;
        chk("bp_xfer_valid", 64'(bcd_valid_o), 64'd0);
        chk("bp_xfer_rdy",   64'(bin_ready_o), 64'd1);
        tick();
        bin_valid_i = 1'b0;
        bin_i       = 32'd1;
        chk("bp_accept_busy", 64'(busy_o), 64'd1);
        wait_valid("bp_second", k);
        chk("bp_second_bcd", 64'(bcd_o),     64'h720);
        chk("bp_second_nd",  64'(ndigits_o), 64'd3);
        bcd_ready_i = 1'b1;
        tick();
        bcd_ready_i = 1'b0;

        // Reset in the middle of SHIFT aborts the conversion.
        bin_i       = 32'd120;
        bin_valid_i = 1'b1;
        tick();
        bin_valid_i = 1'b0;
        for (int c = 0; c < 15; c++)
            tick();
        chk("mid_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy",   64'(bin_ready_o), 64'd1);
        chk("mid_rst_busy",  64'(busy_o),      64'd0);
        chk("mid_rst_valid", 64'(bcd_valid_o), 64'd0);
        chk("mid_rst_bcd",   64'(bcd_o),       64'd0);
        chk("mid_rst_nd",    64'(ndigits_o),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_vec("post_rst", vecs[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
